poly1305_stream_mac: RTL and testbench

// - Streaming Poly1305 MAC engine (RFC 8439) with valid/ready input and output handshakes.
// - Multiply is limb-serial: throughput/area trade-off set by a parameter.
// - Loads a one-time 256-bit key, absorbs 16-byte blocks, then emits a 128-bit tag.
// - Sits beside the chacha20 keystream path as the AEAD authenticator.

---
 rtl/poly1305_stream_mac.sv | 168 ++++++++++++++++
 tb/tb_poly1305_stream_mac.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/poly1305_stream_mac.sv
// Streaming Poly1305 (RFC 8439) MAC: key load, 16-byte block absorb, limb-serial multiply, tag out.
// Optional POLY1305_TAG_CHECK_EN adds the expected_tag input and the tag_match output.
module poly1305_stream_mac #(
  parameter int LIMB_WIDTH = 32
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         key_valid,
  input  logic [255:0] key,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_last,
  input  logic [3:0]   in_bytes_minus_one,
  output logic         tag_valid,
  input  logic         tag_ready,
  output logic [127:0] tag,
`ifdef POLY1305_TAG_CHECK_EN
  input  logic [127:0] expected_tag,
  output logic         tag_match,
`endif
  output logic         busy
);

  localparam int MUL_CYCLES = 128 / LIMB_WIDTH;
  localparam logic [127:0] R_CLAMP = 128'h0ffffffc0ffffffc0ffffffc0fffffff;
  localparam logic [130:0] P = 131'h3_ffffffff_ffffffff_ffffffff_fffffffb;

  typedef enum logic [2:0] {
    S_IDLE, S_ABSORB, S_ADD, S_MUL, S_REDUCE, S_FINAL, S_DONE
  } state_t;

  state_t         state_reg, state_next;
  logic [127:0]   r_reg, s_reg, tag_reg;
  logic [130:0]   acc_reg;
  logic [128:0]   m_reg;
  logic           last_reg;
  logic [258:0]   prod_reg;
  logic [7:0]     mul_cnt_reg;

  // Block padding: keep bytes 0..n, then set the bit just above the last kept byte.
  logic [3:0]     n_eff;
  logic [127:0]   data_masked;
  logic [128:0]   pad_bit, m_next;

  assign n_eff = in_last ? in_bytes_minus_one : 4'hf;

  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    assign data_masked[gi*8 +: 8] = (4'(gi) <= n_eff) ? in_data[gi*8 +: 8] : 8'h00;
  end

  assign pad_bit = 129'd1 << (8'({n_eff, 3'b000}) + 8'd8);
  assign m_next  = {1'b0, data_masked} | pad_bit;

  // One limb of r per cycle, partial product aligned to the limb position.
  logic [8:0]            shamt;
  logic [LIMB_WIDTH-1:0] limb;
  logic [258:0]          mul_term;

  assign shamt    = 9'(mul_cnt_reg) * 9'(LIMB_WIDTH);
  assign limb     = LIMB_WIDTH'(r_reg >> shamt);
  assign mul_term = (259'(acc_reg) * 259'(limb)) << shamt;

  // 2^130 == 5 (mod p): fold the high part back in twice.
  logic [132:0] fold1;
  logic [130:0] fold2, acc_final;
  logic [127:0] tag_next;

  assign fold1     = 133'(prod_reg[258:130]) * 133'd5 + 133'(prod_reg[129:0]);
  assign fold2     = 131'(fold1[132:130]) * 131'd5 + 131'(fold1[129:0]);
  assign acc_final = (acc_reg >= P) ? acc_reg - P : acc_reg;
  assign tag_next  = 128'(acc_final) + s_reg;

  always_ff @(posedge clock) begin
    if (clear) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (key_valid) state_next = S_ABSORB;
      S_ABSORB: if (in_valid) state_next = S_ADD;
      S_ADD:    state_next = S_MUL;
      S_MUL:    if (mul_cnt_reg == 8'(MUL_CYCLES - 1)) state_next = S_REDUCE;
      S_REDUCE: state_next = last_reg ? S_FINAL : S_ABSORB;
      S_FINAL:  state_next = S_DONE;
      S_DONE:   if (tag_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    tag_valid = 1'b0;
    busy      = 1'b1;
    case (state_reg)
      S_IDLE:   busy = 1'b0;
      S_ABSORB: in_ready = 1'b1;
      S_DONE:   tag_valid = 1'b1;
      default:  ;
    endcase
  end

  assign tag = tag_reg;

  always_ff @(posedge clock) begin
    if (clear) begin
      r_reg       <= '0;
      s_reg       <= '0;
      acc_reg     <= '0;
      m_reg       <= '0;
      last_reg    <= 1'b0;
      prod_reg    <= '0;
      mul_cnt_reg <= '0;
      tag_reg     <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (key_valid) begin
            r_reg   <= key[127:0] & R_CLAMP;
            s_reg   <= key[255:128];
            acc_reg <= '0;
          end
        end
        S_ABSORB: begin
          if (in_valid) begin
            m_reg    <= m_next;
            last_reg <= in_last;
          end
        end
        S_ADD: begin
          acc_reg     <= acc_reg + 131'(m_reg);
          prod_reg    <= '0;
          mul_cnt_reg <= '0;
        end
        S_MUL: begin
          prod_reg    <= prod_reg + mul_term;
          mul_cnt_reg <= mul_cnt_reg + 8'd1;
        end
        S_REDUCE: acc_reg <= fold2;
        S_FINAL:  tag_reg <= tag_next;
        default:  ;
      endcase
    end
  end

`ifdef POLY1305_TAG_CHECK_EN
  logic [127:0] exp_tag_reg;
  logic         tag_match_reg;

  always_ff @(posedge clock) begin
    if (clear) begin
      exp_tag_reg   <= '0;
      tag_match_reg <= 1'b0;
    end else begin
      if (state_reg == S_ABSORB && in_valid && in_last) exp_tag_reg <= expected_tag;
      if (state_reg == S_FINAL) tag_match_reg <= (tag_next == exp_tag_reg);
    end
  end

  assign tag_match = tag_match_reg;
`endif

endmodule

// File: tb/tb_poly1305_stream_mac.sv
// Bench for poly1305_stream_mac: big-integer Poly1305 model, RFC 8439 vector, latency and clear checks.
module tb_poly1305_stream_mac;
  localparam int LW = 32;
  localparam int MC = 128 / LW;
  localparam logic [255:0] RFC_KEY = 256'h1bf54941aff6bf4afdb20dfb8a800301_a806d542fe52447f336d555778bed685;
  localparam logic [127:0] RFC_TAG = 128'ha927010caf8b2bc2c6365130c11d06a8;
  localparam logic [127:0] RFC_B0  = 128'h6f4620636968706172676f7470797243;
  localparam logic [127:0] RFC_B1  = 128'h6f7247206863726165736552206d7572;
  localparam logic [127:0] RFC_B2  = 128'h7075;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         clear, key_valid, in_valid, in_ready, in_last, tag_valid, tag_ready, busy;
  logic [255:0] key;
  logic [127:0] in_data, tag, expected_tag;
  logic [3:0]   in_bytes_minus_one;
`ifdef POLY1305_TAG_CHECK_EN
  logic         tag_match;
`endif

  int n_checks = 0;
  int n_fail = 0;

  logic [127:0] blk [4];
  logic [255:0] cur_key;
  logic [127:0] model_tag = '0;

  poly1305_stream_mac #(.LIMB_WIDTH(LW)) u_dut (
    .clock(clock), .clear(clear), .key_valid(key_valid), .key(key),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .in_bytes_minus_one(in_bytes_minus_one), .tag_valid(tag_valid), .tag_ready(tag_ready),
    .tag(tag),
`ifdef POLY1305_TAG_CHECK_EN
    .expected_tag(expected_tag), .tag_match(tag_match),
`endif
    .busy(busy)
  );

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Poly1305 straight from its definition: acc = ((acc + m) * r) mod (2^130 - 5).
  function automatic logic [127:0] model_tag_fn(input logic [255:0] k, input int nb, input logic [3:0] nl);
    logic [263:0] p, r, a, m;
    int nbytes;
    p = (264'd1 << 130) - 264'd5;
    r = 264'(k[127:0] & 128'h0ffffffc0ffffffc0ffffffc0fffffff);
    a = '0;
    for (int i = 0; i < nb; i++) begin
      nbytes = (i == nb - 1) ? int'(nl) + 1 : 16;
      m = '0;
      for (int j = 0; j < nbytes; j++) m[8*j +: 8] = blk[i][8*j +: 8];
      m = m + (264'd1 << (8 * nbytes));
      a = ((a + m) * r) % p;
    end
    a = a + 264'(k[255:128]);
    return a[127:0];
  endfunction

  always @(negedge clock) begin
    if (!clear && tag_valid) check("tag_vs_model", tag, model_tag);
  end

  task automatic send_block(input logic [127:0] d, input logic lst, input logic [3:0] n, output int low);
    in_data = d;
    in_last = lst;
    in_bytes_minus_one = n;
    in_valid = 1'b1;
    low = 0;
    while (!in_ready && low < 1000) begin
      low++;
      @(negedge clock);
    end
    @(negedge clock);
  endtask

  task automatic run_msg(input string nm, input int nb, input logic [3:0] nl, input int hold,
                         input logic use_lit, input logic [127:0] lit);
    logic [127:0] exp;
    int low;
    int cyc;
    exp = model_tag_fn(cur_key, nb, nl);
    if (use_lit) check({nm, "_model_literal"}, exp, lit);
    model_tag = exp;
    key = cur_key;
    key_valid = 1'b1;
    @(negedge clock);
    check({nm, "_busy_after_key"}, 128'(busy), 128'd1);
    key = ~cur_key;  // key_valid left high: must be ignored outside IDLE
    for (int b = 0; b < nb; b++) begin
      send_block(blk[b], b == nb - 1, (b == nb - 1) ? nl : 4'd3, low);
      if (b > 0) check({nm, "_in_ready_low"}, 128'(low), 128'(MC + 2));
    end
    in_valid = 1'b0;
    key_valid = 1'b0;
    cyc = 0;
    while (!tag_valid && cyc < 1000) begin
      cyc++;
      @(negedge clock);
    end
    check({nm, "_tag_valid"}, 128'(tag_valid), 128'd1);
    if (use_lit) check({nm, "_tag_literal"}, tag, lit);
`ifdef POLY1305_TAG_CHECK_EN
    check({nm, "_tag_match"}, 128'(tag_match), 128'(exp == expected_tag));
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check({nm, "_tag_valid_hold"}, 128'(tag_valid), 128'd1);
    end
    tag_ready = 1'b1;
    @(negedge clock);
    tag_ready = 1'b0;
    check({nm, "_tag_valid_drop"}, 128'(tag_valid), 128'd0);
    check({nm, "_busy_idle"}, 128'(busy), 128'd0);
    check({nm, "_tag_kept"}, tag, exp);
    $display("msg %s: %0d blocks, tag %h", nm, nb, tag);
  endtask

  // LIMB_WIDTH sweep: each width runs the RFC vector on its own instance.
  for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
    localparam int W = (gi == 0) ? 8 : (gi == 1) ? 16 : (gi == 2) ? 64 : 128;
    logic sw_clear, sw_kv, sw_iv, sw_ir, sw_il, sw_tv, sw_tr, sw_busy;
    logic sw_done = 1'b0;
    logic [3:0]   sw_nb;
    logic [127:0] sw_d, sw_tag;
`ifdef POLY1305_TAG_CHECK_EN
    logic sw_match;
`endif

    poly1305_stream_mac #(.LIMB_WIDTH(W)) u_sweep (
      .clock(clock), .clear(sw_clear), .key_valid(sw_kv), .key(RFC_KEY),
      .in_valid(sw_iv), .in_ready(sw_ir), .in_data(sw_d), .in_last(sw_il),
      .in_bytes_minus_one(sw_nb), .tag_valid(sw_tv), .tag_ready(sw_tr), .tag(sw_tag),
`ifdef POLY1305_TAG_CHECK_EN
      .expected_tag(RFC_TAG), .tag_match(sw_match),
`endif
      .busy(sw_busy)
    );

    initial begin
      int low;
      sw_clear = 1'b1; sw_kv = 1'b0; sw_iv = 1'b0; sw_il = 1'b0; sw_tr = 1'b0;
      sw_nb = 4'd0; sw_d = '0;
      repeat (3) @(negedge clock);
      sw_clear = 1'b0;
      sw_kv = 1'b1;
      @(negedge clock);
      sw_kv = 1'b0;
      for (int b = 0; b < 3; b++) begin
        sw_d  = (b == 0) ? RFC_B0 : (b == 1) ? RFC_B1 : RFC_B2;
        sw_il = (b == 2);
        sw_nb = (b == 2) ? 4'd1 : 4'd15;
        sw_iv = 1'b1;
        low = 0;
        while (!sw_ir && low < 1000) begin
          low++;
          @(negedge clock);
        end
        if (b > 0) check($sformatf("sweep%0d_in_ready_low", W), 128'(low), 128'(128 / W + 2));
        @(negedge clock);
      end
      sw_iv = 1'b0;
      low = 0;
      while (!sw_tv && low < 1000) begin
        low++;
        @(negedge clock);
      end
      check($sformatf("sweep%0d_tag", W), sw_tag, RFC_TAG);
      $display("sweep LIMB_WIDTH=%0d: tag %h", W, sw_tag);
      sw_tr = 1'b1;
      @(negedge clock);
      sw_tr = 1'b0;
      sw_done = 1'b1;
    end
  end

  initial begin
    int low;
    clear = 1'b1; key_valid = 1'b0; key = '0; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; in_bytes_minus_one = 4'd0; tag_ready = 1'b0; expected_tag = RFC_TAG;
    repeat (3) @(negedge clock);
    check("reset_in_ready", 128'(in_ready), 128'd0);
    check("reset_tag_valid", 128'(tag_valid), 128'd0);
    check("reset_tag", tag, 128'd0);
    check("reset_busy", 128'(busy), 128'd0);
    clear = 1'b0;

    cur_key = RFC_KEY;
    blk[0] = RFC_B0; blk[1] = RFC_B1; blk[2] = RFC_B2;
    run_msg("rfc", 3, 4'd1, 10, 1'b1, RFC_TAG);

    cur_key = '0;
    blk[0] = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    blk[1] = 128'h55aa55aa_12345678_9abcdef0_0f1e2d3c;
    blk[2] = 128'hffffffff_ffffffff_ffffffff_ffffffff;
    run_msg("zero_key", 3, 4'd7, 0, 1'b1, 128'd0);

    cur_key = 256'h00000000_00000000_00000000_00000001_00000000_00000000_00000000_00000000;
    blk[0] = 128'h00112233_44556677_8899aabb_ccddeeff;
    run_msg("s_one", 1, 4'd15, 0, 1'b1, 128'd1);

    cur_key = '1;
    blk[0] = '1; blk[1] = '1;
    run_msg("all_ones", 2, 4'd0, 2, 1'b0, 128'd0);

    // Abort the RFC message while block 2 is in the multiplier.
    cur_key = RFC_KEY;
    blk[0] = RFC_B0; blk[1] = RFC_B1; blk[2] = RFC_B2;
    key = cur_key;
    key_valid = 1'b1;
    @(negedge clock);
    key_valid = 1'b0;
    send_block(RFC_B0, 1'b0, 4'd15, low);
    send_block(RFC_B1, 1'b0, 4'd15, low);
    in_valid = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    check("clear_busy", 128'(busy), 128'd0);
    check("clear_in_ready", 128'(in_ready), 128'd0);
    check("clear_tag_valid", 128'(tag_valid), 128'd0);
    check("clear_tag", tag, 128'd0);
    $display("clear asserted during MUL of block 2");
    clear = 1'b0;
    @(negedge clock);
    run_msg("rfc_after_clear", 3, 4'd1, 0, 1'b1, RFC_TAG);

    expected_tag = RFC_TAG ^ 128'h20_0000_0000;
    run_msg("rfc_bad_expected", 3, 4'd1, 0, 1'b1, RFC_TAG);

    for (int c = 0; c < 5000 && !(g_sweep[0].sw_done && g_sweep[1].sw_done &&
                                  g_sweep[2].sw_done && g_sweep[3].sw_done); c++)
      @(negedge clock);
    check("sweep_complete",
          128'({g_sweep[3].sw_done, g_sweep[2].sw_done, g_sweep[1].sw_done, g_sweep[0].sw_done}),
          128'hf);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
